// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, tracks the two-phase imem_ready handshake,
// and buffers returned instructions with their PCs in a small FIFO for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        imem_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     pend_pc_q, pend_pc_d;
    logic            pend_q, pend_d;
    logic [CntW-1:0] count_q, count_d, count_next;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]     buf_instr_q [DEPTH];
    logic [31:0]     buf_pc_q    [DEPTH];
    logic            push, pop, issue;

    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_addr = pc_q;
    assign dec_valid = (count_q != '0);
    // Gate the head so an empty FIFO presents zeros rather than stale data.
    assign dec_instr = dec_valid ? buf_instr_q[rd_ptr_q] : '0;
    assign dec_pc    = dec_valid ? buf_pc_q[rd_ptr_q] : '0;

    always_comb begin
        pop        = dec_valid && dec_ready && !redirect_valid;
        push       = imem_ready && pend_q && !redirect_valid;
        count_next = count_q + CntW'(push) - CntW'(pop);
        // The outstanding request is always answered at a ready edge, so only
        // the buffered count limits whether the newly captured address is kept.
        issue      = imem_ready && !redirect_valid && (count_next < DepthCnt);

        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;

        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            pend_d   = 1'b0;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d = count_next;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (imem_ready) begin
                pend_d = issue;
                if (issue) begin
                    pend_pc_d = pc_q;
                    pc_d      = pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_instr;
            buf_pc_q[wr_ptr_q]    <= pend_pc_q;
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        push |-> (count_q < DepthCnt));

endmodule
